ssd_scan_ctrl: RTL and testbench
================================

# ssd_scan_ctrl

Time-multiplexed scan controller for a 4-digit common-anode seven-segment display. It shares one `ssd_driver` decoder across all four digits: every refresh slot it selects one BCD nibble, drives it to the decoder input, and enables the matching anode. Display values are loaded through a tear-free shadow register that commits only at frame boundaries. The block sits between the temperature-conversion datapath (BCD producer) and the board display pins.

## Interface

Parameters:
- `REFRESH_DIV`, default 100000: clock cycles per digit slot (1 kHz per digit at 100 MHz). Legal range is ≥ 2.
- `BLANK_CYCLES`, default 1000: anti-ghosting dead time at the start of each slot. Legal range is 1 .. REFRESH_DIV-1.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high reset.
- `val_in` in 16: four BCD nibbles; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
- `dp_in` in 4: decimal-point enables, one per digit, active-high.
- `load` in 1: single-cycle strobe that captures `val_in`/`dp_in` into the shadow register.
- `lz_en` in 1: leading-zero blanking enable, sampled live.
- `digit_out` out 4: nibble for the selected digit; connects to decoder `inp`.
- `an` out 4: anode enables, active-low.
- `dp_n` out 1: decimal point, active-low.
- `ack` out 1: one-cycle pulse when a loaded value commits to the display.

## Operation

- **Reset (synchronous, active-high).** All outputs are registered. Reset values:
  - `an` = 4'b1111, `digit_out` = 0, `dp_n` = 1, `ack` = 0
  - internal: slot counter `cnt` = 0, digit index `idx` = 0, `active` = 0, `shadow` = 0, `pending` = 0
- **Slot counter.** `cnt` counts 0..REFRESH_DIV-1 and wraps. When `cnt` = REFRESH_DIV-1, `idx` increments modulo 4 (3 wraps to 0).
- **Frame boundary.** The cycle where `cnt` = REFRESH_DIV-1 and `idx` = 3.
- **Load and commit.**
  - `load` = 1 sets `shadow` ← {`dp_in`, `val_in`} and `pending` ← 1.
  - A later `load` before commit overwrites `shadow`; only the last value is committed.
  - At a frame boundary with `pending` = 1: `active` ← `shadow`, `pending` ← 0.
  - `load` on the boundary cycle itself bypasses the shadow: `active` ← {`dp_in`, `val_in`} and `pending` ← 0.
  - A commit with no pending load and no `load` on the boundary leaves `active` unchanged and does not pulse `ack`.
- **Digit selection.** The selected nibble is `active` nibble[`idx`]. `digit_out` updates at slot start.
- **Anode enable.**
  - `an[idx]` = 0 only when `cnt` ≥ BLANK_CYCLES and the digit is not blanked. All other anodes are always 1.
- **Blanking.** A digit is blanked (anode held high for the whole slot) in either case:
  - Its nibble is > 9. The decoder output is undefined for those codes, so the anode must stay off.
  - `lz_en` = 1, `idx` ≥ 1, and that nibble and every higher nibble are 0. Digit 0 is never zero-blanked.
- **Decimal point.** `dp_n` = ~dp bit[`idx`], gated exactly like `an[idx]`. When the anode is off, `dp_n` = 1.

## Timing

- **Output pipeline.** Outputs are registered from the counter and index state, one cycle behind them.
  - Slot k spans cycles where `cnt` = 0..REFRESH_DIV-1 for index k.
  - `digit_out` changes on the cycle after `cnt` = 0 of the new slot. `an` is 4'b1111 at that same edge.
  - `an` goes low BLANK_CYCLES cycles into the slot and stays low through the slot's final output cycle. The decoder therefore settles while all anodes are off.
- **Ack.** `ack` is high for exactly one cycle, the cycle after the commit edge.
- **Load-to-display latency.** The new value reaches digit 0's anode at most 4·REFRESH_DIV + BLANK_CYCLES + 1 cycles after `load`.
- **Frame period.** Exactly 4·REFRESH_DIV cycles.
- **Reset mid-slot.** Within one edge: anodes off, `pending` dropped, `active` cleared, no `ack`. Scanning restarts at digit 0 with `cnt` = 0.
- **`lz_en` changes** take effect at the next output register update. They are not frame-aligned.

## Test plan

Run all scenarios with REFRESH_DIV = 8 and BLANK_CYCLES = 2.

1. **Reset then idle scan.**
   - Stimulus: reset for 3 cycles, release, run 64 cycles.
   - Required: `an` = 1111 during reset. After release, the pattern 1110/1101/1011/0111 repeats every 32 cycles, with 2 all-high cycles at each slot start. `digit_out` = 0, `dp_n` = 1, `ack` = 0 throughout.
2. **Load and commit.**
   - Stimulus: `load` with `val_in` = 16'h1234, `dp_in` = 4'b0010 mid-frame.
   - Required: display unchanged until the frame boundary. `ack` pulses once, one cycle after the boundary. The following frame shows digits 4, 3, 2, 1 on `idx` 0..3, and `dp_n` = 0 only during digit 1's enabled window.
3. **Back-to-back and boundary loads.**
   - Stimulus: load 16'h1111 then 16'h2222 in the same frame; separately, assert `load` with 16'h5678 exactly on a boundary cycle.
   - Required: only 2222 is displayed, with a single `ack`. 5678 is displayed from the immediately following frame, with one `ack`.
4. **Leading-zero blanking.**
   - Stimulus: `active` = 16'h0050 with `lz_en` = 1, then `lz_en` = 0; then 16'h0000 with `lz_en` = 1.
   - Required: with `lz_en` = 1, digits 3 and 2 are never enabled while digits 1 and 0 are enabled. With `lz_en` = 0, all four are enabled. For 0000, only digit 0 is enabled.
5. **Invalid nibble.**
   - Stimulus: 16'h9A09.
   - Required: digit 2 (A) has `an[2]` = 1 for its whole slot. Digits 0, 1 and 3 are enabled normally.
6. **Reset mid-operation.**
   - Stimulus: reset asserted while `pending` = 1 during slot 2.
   - Required: the next cycle shows `an` = 1111 and `ack` = 0. After release, the display shows 0 and no `ack` occurs at the next boundary.

Source files
------------

// File: rtl/ssd_scan_ctrl.sv
// ssd_scan_ctrl
//   Time-multiplexed scan controller for a 4-digit common-anode seven-segment
//   display. One shared decoder is fed the BCD nibble of the digit currently
//   being scanned while the matching anode is enabled. Display values are
//   loaded into a shadow register and committed only at frame boundaries so a
//   frame never shows a mix of old and new digits.
//
// Ports
//   clk        : single clock
//   reset      : synchronous, active-high reset
//   val_in     : four BCD nibbles, [3:0] = digit 0 (rightmost)
//   dp_in      : decimal-point enables per digit, active-high
//   load       : one-cycle strobe capturing val_in/dp_in
//   lz_en      : leading-zero blanking enable (sampled live)
//   digit_out  : nibble of the selected digit, to the decoder input
//   an         : anode enables, active-low
//   dp_n       : decimal point, active-low
//   ack        : one-cycle pulse when a loaded value commits to the display
module ssd_scan_ctrl #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] val_in,
    input  logic [3:0]  dp_in,
    input  logic        load,
    input  logic        lz_en,
    output logic [3:0]  digit_out,
    output logic [3:0]  an,
    output logic        dp_n,
    output logic        ack
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);

    logic [CNT_W-1:0] cnt;
    logic [1:0]       idx;
    logic [19:0]      active;   // {dp[3:0], bcd[15:0]} currently displayed
    logic [19:0]      shadow;   // last loaded value awaiting commit
    logic             pending;

    logic             frame_end;
    logic [3:0]       sel_nib;
    logic [3:0]       dp_bits;
    logic             sel_dp;
    logic             zero_run;
    logic             blank;
    logic             enable;
    logic [3:0]       an_next;

    always_comb begin
        frame_end = (cnt == CNT_LAST) && (idx == 2'd3);
        dp_bits   = active[19:16];
        sel_dp    = dp_bits[idx];

        sel_nib  = active[3:0];
        zero_run = 1'b0;
        // zero_run: this nibble and every higher one are zero. Digit 0 is
        // never zero-blanked so a value of 0000 still shows a single "0".
        case (idx)
            2'd0: begin
                sel_nib  = active[3:0];
                zero_run = 1'b0;
            end
            2'd1: begin
                sel_nib  = active[7:4];
                zero_run = (active[15:4] == 12'd0);
            end
            2'd2: begin
                sel_nib  = active[11:8];
                zero_run = (active[15:8] == 8'd0);
            end
            default: begin
                sel_nib  = active[15:12];
                zero_run = (active[15:12] == 4'd0);
            end
        endcase

        // Codes A..F have no defined decoder pattern, so keep the anode off.
        blank   = (sel_nib > 4'd9) || (lz_en && zero_run);
        // The first BLANK_CYCLES of every slot keep all anodes off while the
        // decoder settles on the new nibble (anti-ghosting).
        enable  = (cnt >= CNT_BLANK) && !blank;
        an_next = enable ? ~(4'b0001 << idx) : 4'b1111;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            idx       <= 2'd0;
            active    <= '0;
            shadow    <= '0;
            pending   <= 1'b0;
            an        <= 4'b1111;
            digit_out <= 4'd0;
            dp_n      <= 1'b1;
            ack       <= 1'b0;
        end else begin
            // Slot counter and digit index
            if (cnt == CNT_LAST) begin
                cnt <= '0;
                idx <= idx + 2'd1;
            end else begin
                cnt <= cnt + 1'b1;
            end

            // Load / commit. A load landing on the boundary cycle goes straight
            // to the display instead of waiting a whole frame in the shadow.
            if (frame_end) begin
                if (load) begin
                    active <= {dp_in, val_in};
                end else if (pending) begin
                    active <= shadow;
                end
                pending <= 1'b0;
                ack     <= load || pending;
            end else begin
                if (load) begin
                    shadow  <= {dp_in, val_in};
                    pending <= 1'b1;
                end
                ack <= 1'b0;
            end

            // Output register: one cycle behind cnt/idx
            digit_out <= sel_nib;
            an        <= an_next;
            dp_n      <= enable ? ~sel_dp : 1'b1;
        end
    end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Testbench for ssd_scan_ctrl. A driver issues directed and random stimulus
// and, for every clock edge, pushes the expected output packet computed by a
// frame-level reference model. A separate monitor pops and compares after
// each rising edge.
module tb_ssd_scan_ctrl;

    localparam int R  = 8;
    localparam int B  = 2;
    localparam int FR = 4 * R;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] val_in;
    logic [3:0]  dp_in;
    logic        load;
    logic        lz_en;
    logic [3:0]  digit_out;
    logic [3:0]  an;
    logic        dp_n;
    logic        ack;

    always #5 clk = ~clk;

    ssd_scan_ctrl #(.REFRESH_DIV(R), .BLANK_CYCLES(B)) dut (
        .clk       (clk),
        .reset     (reset),
        .val_in    (val_in),
        .dp_in     (dp_in),
        .load      (load),
        .lz_en     (lz_en),
        .digit_out (digit_out),
        .an        (an),
        .dp_n      (dp_n),
        .ack       (ack)
    );

    typedef struct packed {
        logic [3:0] an;
        logic [3:0] digit;
        logic       dp_n;
        logic       ack;
    } exp_t;

    exp_t q[$];
    exp_t exp_e;
    exp_t got_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   started = 1'b0;

    // Reference model: position inside the frame is plain arithmetic on a
    // cycle count since reset release.
    int          m_n = 0;
    logic [19:0] m_active = '0;
    logic [19:0] m_shadow = '0;
    bit          m_pending = 1'b0;
    bit          cur_lz = 1'b0;

    function automatic bit is_blank(input logic [15:0] v, input int i, input bit lz);
        logic [15:0] upper;
        logic [15:0] nib;
        upper = v >> (4 * i);
        nib   = upper & 16'h000F;
        if (nib > 16'd9) return 1'b1;
        if (lz && i >= 1 && upper == 16'd0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic cyc(input bit r, input bit ld, input logic [15:0] v,
                       input logic [3:0] d, input bit lz);
        exp_t e;
        int   c;
        int   i;
        bit   on;
        logic [15:0] shifted;
        logic [3:0]  dps;
        @(negedge clk);
        reset  = r;
        load   = ld;
        val_in = v;
        dp_in  = d;
        lz_en  = lz;
        if (r) begin
            e = '{an: 4'hF, digit: 4'h0, dp_n: 1'b1, ack: 1'b0};
            m_n = 0;
            m_active = '0;
            m_shadow = '0;
            m_pending = 1'b0;
        end else begin
            c = m_n % R;
            i = m_n / R;
            shifted = m_active[15:0] >> (4 * i);
            dps = m_active[19:16];
            on = (c >= B) && !is_blank(m_active[15:0], i, lz);
            e.digit = shifted[3:0];
            e.an    = on ? ~(4'b0001 << i) : 4'hF;
            e.dp_n  = on ? ~dps[i] : 1'b1;
            e.ack   = (m_n == FR - 1) && (ld || m_pending);
            if (m_n == FR - 1) begin
                if (ld) m_active = {d, v};
                else if (m_pending) m_active = m_shadow;
                m_pending = 1'b0;
            end else if (ld) begin
                m_shadow = {d, v};
                m_pending = 1'b1;
            end
            m_n = (m_n + 1) % FR;
        end
        q.push_back(e);
        started = 1'b1;
    endtask

    task automatic idle(input int k);
        for (int j = 0; j < k; j++) cyc(1'b0, 1'b0, 16'($urandom), 4'($urandom), cur_lz);
    endtask

    task automatic wait_pos(input int target);
        while (m_n != target) idle(1);
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        cyc(1'b0, 1'b1, v, d, cur_lz);
    endtask

    // Monitor
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (started) begin
                n_tests++;
                got_e = '{an: an, digit: digit_out, dp_n: dp_n, ack: ack};
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL outputs at %0t: got %h, no expected packet queued", $time, got_e);
                end else begin
                    exp_e = q.pop_front();
                    if (got_e !== exp_e) begin
                        n_fail++;
                        $display("FAIL outputs at %0t: got an=%b digit=%h dp_n=%b ack=%b, expected an=%b digit=%h dp_n=%b ack=%b",
                                 $time, got_e.an, got_e.digit, got_e.dp_n, got_e.ack,
                                 exp_e.an, exp_e.digit, exp_e.dp_n, exp_e.ack);
                    end
                end
            end
        end
    end

    // Driver
    initial begin
        reset  = 1'b1;
        load   = 1'b0;
        val_in = 16'h0;
        dp_in  = 4'h0;
        lz_en  = 1'b0;

        // 1: reset then idle scan
        repeat (3) cyc(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
        idle(64);

        // 2: load mid-frame, commit at boundary
        wait_pos(10);
        do_load(16'h1234, 4'b0010);
        idle(80);

        // 3: back-to-back loads, then a load on the boundary cycle
        wait_pos(3);
        do_load(16'h1111, 4'h0);
        idle(4);
        do_load(16'h2222, 4'h0);
        idle(70);
        wait_pos(FR - 1);
        do_load(16'h5678, 4'h0);
        idle(40);

        // 4: leading-zero blanking
        cur_lz = 1'b1;
        wait_pos(5);
        do_load(16'h0050, 4'h0);
        idle(70);
        cur_lz = 1'b0;
        idle(40);
        cur_lz = 1'b1;
        wait_pos(5);
        do_load(16'h0000, 4'h0);
        idle(70);

        // 5: invalid nibble
        cur_lz = 1'b0;
        do_load(16'h9A09, 4'b1111);
        idle(70);

        // 6: reset while a load is pending during slot 2
        wait_pos(0);
        do_load(16'h4321, 4'b0101);
        wait_pos(2 * R + 3);
        cyc(1'b1, 1'b0, 16'h0, 4'h0, cur_lz);
        idle(70);

        // Random traffic
        for (int k = 0; k < 3000; k++) begin
            bit r;
            bit ld;
            logic [15:0] v;
            r  = ($urandom % 400) == 0;
            ld = ($urandom % 16) == 0;
            if (m_n == FR - 1 && ($urandom % 2) == 1) ld = 1'b1;
            v  = 16'($urandom) >> $urandom_range(0, 16);
            if (($urandom % 64) == 0) cur_lz = ~cur_lz;
            cyc(r, ld, v, 4'($urandom), cur_lz);
        end

        @(posedge clk);
        #2;
        if (q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL queue_drain: %0d packets left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
